command_scheduler: RTL and testbench
====================================

// Module: command_scheduler
// PURPOSE
//  Shares the single PSL command interface between NUM_REQ AFU-internal
//  requesters (read/write engines) and sequences the command/response flow.
//  Round-robin arbitration, PSL credit tracking, and tag allocation and retire
//  with an owner table. Sits between the per-job engines and
//  command_out/response in the AFU top. Also provides drain/idle status for
//  job-done sequencing.
// PARAMETERS
//  NUM_REQ    4    number of requesters (2..8)
//  NUM_TAGS   32   tag pool size; tags 0..NUM_TAGS-1 (power of 2, <=256)
//  CRED_W     9    width of the credit counter (holds PSL room, max 255)
// PORTS
//  clock         in   1            rising-edge clock
//  reset         in   1            synchronous, active-high reset
//  job_start     in   1            pulse: load credits from room, enter RUN
//  room          in   8            PSL command room (ha_croom), sampled on job_start
//  drain         in   1            level: stop granting, wait for outstanding==0
//  req_valid     in   NUM_REQ      per-requester command request
//  req_command   in   NUM_REQ*13   per-requester command code
//  req_address   in   NUM_REQ*64   per-requester effective address
//  req_size      in   NUM_REQ*12   per-requester transfer size
//  req_grant     out  NUM_REQ      one-hot accept pulse (request consumed this cycle)
//  grant_tag     out  8            tag assigned to the granted request
//  cmd_valid     out  1            command_out.valid
//  cmd_command   out  13           command_out.command
//  cmd_address   out  64           command_out.address
//  cmd_size      out  12           command_out.size
//  cmd_tag       out  8            command_out.tag
//  resp_valid    in   1            response.valid
//  resp_tag      in   8            response.tag
//  resp_credits  in   9            response.credits (signed)
//  done_valid    out  1            retired-tag pulse to owner
//  done_owner    out  3            requester index owning the retired tag
//  done_tag      out  8            retired tag
//  outstanding   out  9            tags currently in flight
//  drained       out  1            level: state DRAINED
//  error         out  1            sticky protocol error
// BEHAVIOUR
//  - Reset: state IDLE, credits=0, all tags free, rr pointer=0; every output 0.
//  - FSM: IDLE -job_start-> RUN; RUN -drain-> DRAIN;
//    DRAIN -outstanding==0-> DRAINED; DRAINED -job_start-> RUN.
//    A job_start in RUN or DRAIN is ignored and sets error.
//  - Grant condition: state==RUN && credits>0 && any free tag && any req_valid.
//    req_grant is combinational from registered state and req_valid.
//  - Round-robin: search starts at rr_ptr; after a grant, rr_ptr = winner+1 mod NUM_REQ.
//  - Tag: lowest-index free tag. On grant the tag is marked busy and
//    owner[tag] = winner.
//  - Latency: cmd_* is registered, cmd_valid asserts the cycle after grant,
//    for exactly one cycle. Max one command per cycle.
//  - Credits: next = credits - grant + (resp_valid ? resp_credits : 0).
//    A simultaneous grant and response apply both in the same cycle.
//  - Credit range: a result above the loaded room, or below 0, sets error;
//    credits clamp to [0, room].
//  - Response, tag busy: the tag is freed at the clock edge (reusable in the
//    next cycle's grant). done_valid/owner/tag are registered and assert
//    1 cycle after resp_valid.
//  - Response, tag free or >= NUM_TAGS: sets error. No table change, no done_valid.
//  - outstanding = popcount of busy tags, registered. drained=1 only in DRAINED.
//  - error clears only on reset. Mid-operation reset drops all in-flight
//    state and any pending cmd_valid in the same cycle.
// TESTING
//  T1 reset, job_start room=4, req0 valid x6 -> 4 grants (tags 0,1,2,3),
//     cmd_valid 1 cycle after each, then stall with credits=0.
//  T2 all 4 req_valid held -> grant order 0,1,2,3,0; with the pool exhausted
//     (NUM_TAGS busy) -> no grant until a response.
//  T3 resp tag=2 credits=+1 in the same cycle as a grant -> credits unchanged,
//     tag 2 granted next cycle, done_owner = original owner of tag 2.
//  T4 drain with 3 outstanding -> no grants; 3 responses -> drained=1 on the
//     cycle after the last retire; job_start -> RUN.
//  T5 resp on free tag 7 -> error=1, no done_valid; credits +5 beyond room
//     -> error, credits clamped to room.
//  T6 reset asserted one cycle after a grant -> cmd_valid=0, outstanding=0,
//     credits=0, state IDLE.

Source files
------------

// File: rtl/command_scheduler.sv
// command_scheduler: round-robin PSL command arbiter with credit, tag and drain tracking
module command_scheduler #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_TAGS = 32,
  parameter int CRED_W   = 9
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_job_start,
  input  logic [7:0]              i_room,
  input  logic                    i_drain,
  input  logic [NUM_REQ-1:0]      i_req_valid,
  input  logic [NUM_REQ*13-1:0]   i_req_command,
  input  logic [NUM_REQ*64-1:0]   i_req_address,
  input  logic [NUM_REQ*12-1:0]   i_req_size,
  output logic [NUM_REQ-1:0]      o_req_grant,
  output logic [7:0]              o_grant_tag,
  output logic                    o_cmd_valid,
  output logic [12:0]             o_cmd_command,
  output logic [63:0]             o_cmd_address,
  output logic [11:0]             o_cmd_size,
  output logic [7:0]              o_cmd_tag,
  input  logic                    i_resp_valid,
  input  logic [7:0]              i_resp_tag,
  input  logic [8:0]              i_resp_credits,
  output logic                    o_done_valid,
  output logic [2:0]              o_done_owner,
  output logic [7:0]              o_done_tag,
  output logic [8:0]              o_outstanding,
  output logic                    o_drained,
  output logic                    o_error
);
  localparam int RW = $clog2(NUM_REQ);
  localparam int TW = $clog2(NUM_TAGS);
  localparam int SW = CRED_W + 2;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DRAINED} state_t;
  state_t               r_state, w_state_next;
  logic [CRED_W-1:0]    r_credits, w_cred_next;
  logic [7:0]           r_room;
  logic [NUM_TAGS-1:0]  r_busy, w_busy_next;
  logic [2:0]           r_owner [NUM_TAGS];
  logic [RW-1:0]        r_rr, w_win, w_idx;
  logic [TW-1:0]        w_tag, w_rtag;
  logic [8:0]           r_outstanding, w_count;
  logic signed [SW-1:0] w_resp_add, w_sum, w_room_s;
  logic                 w_found, w_free, w_grant, w_start_ok, w_start_err;
  logic                 w_resp_hit, w_resp_err, w_neg, w_over, w_cred_err;
  logic                 r_cmd_valid, r_done_valid, r_error;
  logic [12:0]          r_cmd_command;
  logic [63:0]          r_cmd_address;
  logic [11:0]          r_cmd_size;
  logic [7:0]           r_cmd_tag, r_done_tag;
  logic [2:0]           r_done_owner;
  // round-robin winner starting at the pointer, and the lowest-index free tag
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    w_free  = 1'b0;
    w_tag   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = RW'((int'(r_rr) + i) % NUM_REQ);
      if (!w_found && i_req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
    for (int t = NUM_TAGS - 1; t >= 0; t--)
      if (!r_busy[t]) begin
        w_free = 1'b1;
        w_tag  = TW'(t);
      end
  end
  assign w_grant     = !i_reset && r_state == S_RUN && r_credits != '0 && w_free && w_found;
  assign o_req_grant = w_grant ? (NUM_REQ'(1) << w_win) : '0;
  assign o_grant_tag = w_grant ? 8'(w_tag) : 8'd0;
  assign w_rtag      = i_resp_tag[TW-1:0];
  assign w_resp_hit  = i_resp_valid && 32'(i_resp_tag) < 32'(NUM_TAGS) && r_busy[w_rtag];
  assign w_resp_err  = i_resp_valid && !w_resp_hit;
  assign w_start_ok  = i_job_start && (r_state == S_IDLE || r_state == S_DRAINED);
  assign w_start_err = i_job_start && (r_state == S_RUN || r_state == S_DRAIN);
  // tag table after this cycle's grant and retire, and its population count
  always_comb begin
    w_busy_next = r_busy;
    if (w_grant) w_busy_next[w_tag] = 1'b1;
    if (w_resp_hit) w_busy_next[w_rtag] = 1'b0;
    w_count = '0;
    for (int t = 0; t < NUM_TAGS; t++) w_count = w_count + 9'(w_busy_next[t]);
  end
  // signed credit update, clamped to [0, room]; leaving that range is an error
  always_comb begin
    w_resp_add  = i_resp_valid ? SW'($signed(i_resp_credits)) : '0;
    w_room_s    = $signed(SW'(r_room));
    w_sum       = $signed(SW'(r_credits)) - SW'(w_grant) + w_resp_add;
    w_neg       = w_sum[SW-1];
    w_over      = !w_neg && w_sum > w_room_s;
    w_cred_err  = !w_start_ok && (w_neg || w_over);
    w_cred_next = w_neg ? '0 : w_over ? CRED_W'(r_room) : w_sum[CRED_W-1:0];
  end
  // job state: run after job_start, drain on request, drained once nothing is in flight
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DRAINED: if (i_job_start) w_state_next = S_RUN;
      S_RUN:             if (i_drain) w_state_next = S_DRAIN;
      S_DRAIN:           if (r_outstanding == '0) w_state_next = S_DRAINED;
      default:           w_state_next = S_IDLE;
    endcase
  end
  // all registered state: tags, owners, credits, command and retire outputs
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_credits     <= '0;
      r_room        <= '0;
      r_busy        <= '0;
      r_rr          <= '0;
      r_outstanding <= '0;
      r_cmd_valid   <= 1'b0;
      r_cmd_command <= '0;
      r_cmd_address <= '0;
      r_cmd_size    <= '0;
      r_cmd_tag     <= '0;
      r_done_valid  <= 1'b0;
      r_done_owner  <= '0;
      r_done_tag    <= '0;
      r_error       <= 1'b0;
      for (int t = 0; t < NUM_TAGS; t++) r_owner[t] <= '0;
    end else begin
      r_state       <= w_state_next;
      r_busy        <= w_busy_next;
      r_outstanding <= w_count;
      r_credits     <= w_start_ok ? CRED_W'(i_room) : w_cred_next;
      if (w_start_ok) r_room <= i_room;
      r_cmd_valid   <= w_grant;
      if (w_grant) begin
        r_owner[w_tag] <= 3'(w_win);
        r_rr           <= RW'((int'(w_win) + 1) % NUM_REQ);
        r_cmd_command  <= i_req_command[int'(w_win)*13 +: 13];
        r_cmd_address  <= i_req_address[int'(w_win)*64 +: 64];
        r_cmd_size     <= i_req_size[int'(w_win)*12 +: 12];
        r_cmd_tag      <= 8'(w_tag);
      end
      r_done_valid  <= w_resp_hit;
      r_done_owner  <= w_resp_hit ? r_owner[w_rtag] : 3'd0;
      r_done_tag    <= w_resp_hit ? i_resp_tag : 8'd0;
      r_error       <= r_error || w_start_err || w_resp_err || w_cred_err;
    end
  end
  assign o_cmd_valid   = r_cmd_valid && !i_reset;
  assign o_cmd_command = r_cmd_command;
  assign o_cmd_address = r_cmd_address;
  assign o_cmd_size    = r_cmd_size;
  assign o_cmd_tag     = r_cmd_tag;
  assign o_done_valid  = r_done_valid && !i_reset;
  assign o_done_owner  = r_done_owner;
  assign o_done_tag    = r_done_tag;
  assign o_outstanding = r_outstanding;
  assign o_drained     = r_state == S_DRAINED;
  assign o_error       = r_error;
endmodule

// File: tb/tb_command_scheduler.sv
// tb_command_scheduler: directed scenarios plus random traffic against a behavioural model
module tb_command_scheduler;
  localparam int NR = 4;
  localparam int NT = 32;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic            rst, job_start, drain, resp_valid;
  logic [7:0]      room, resp_tag;
  logic [8:0]      resp_credits;
  logic [NR-1:0]   req_valid, req_grant;
  logic [NR*13-1:0] req_command;
  logic [NR*64-1:0] req_address;
  logic [NR*12-1:0] req_size;
  logic [7:0]      grant_tag, cmd_tag, done_tag;
  logic            cmd_valid, done_valid, drained, error;
  logic [12:0]     cmd_command;
  logic [63:0]     cmd_address;
  logic [11:0]     cmd_size;
  logic [2:0]      done_owner;
  logic [8:0]      outstanding;

  command_scheduler #(.NUM_REQ(NR), .NUM_TAGS(NT), .CRED_W(9)) dut (
    .i_clock(clk), .i_reset(rst), .i_job_start(job_start), .i_room(room), .i_drain(drain),
    .i_req_valid(req_valid), .i_req_command(req_command), .i_req_address(req_address),
    .i_req_size(req_size), .o_req_grant(req_grant), .o_grant_tag(grant_tag),
    .o_cmd_valid(cmd_valid), .o_cmd_command(cmd_command), .o_cmd_address(cmd_address),
    .o_cmd_size(cmd_size), .o_cmd_tag(cmd_tag), .i_resp_valid(resp_valid),
    .i_resp_tag(resp_tag), .i_resp_credits(resp_credits), .o_done_valid(done_valid),
    .o_done_owner(done_owner), .o_done_tag(done_tag), .o_outstanding(outstanding),
    .o_drained(drained), .o_error(error));

  int n_cmp = 0, n_bad = 0;
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // model state: 0 idle, 1 run, 2 drain, 3 drained
  int m_state, m_cred, m_room, m_rr, m_out;
  bit m_err;
  bit m_busy [NT];
  int m_owner [NT];
  bit e_cv, e_dv;
  logic [12:0] e_cc;
  logic [63:0] e_ca;
  logic [11:0] e_cs;
  int e_ct, e_do, e_dt;
  bit g_ok;
  int g_win, g_tag;
  int dut_grants = 0;
  logic [NR-1:0] last_grant;
  logic [7:0] last_tag;

  function automatic void model_comb();
    g_ok = 0; g_win = 0; g_tag = -1;
    if (rst || m_state != 1 || m_cred <= 0) return;
    for (int t = 0; t < NT; t++) if (!m_busy[t]) begin g_tag = t; break; end
    if (g_tag < 0) return;
    for (int k = 0; k < NR; k++)
      if (req_valid[(m_rr + k) % NR]) begin g_win = (m_rr + k) % NR; g_ok = 1; break; end
  endfunction

  task automatic model_clock();
    int rc, sum, old_state;
    bit hit, start_ok;
    if (rst) begin
      m_state = 0; m_cred = 0; m_room = 0; m_rr = 0; m_out = 0; m_err = 0;
      for (int t = 0; t < NT; t++) begin m_busy[t] = 0; m_owner[t] = 0; end
      e_cv = 0; e_dv = 0;
      return;
    end
    old_state = m_state;
    rc = resp_credits[8] ? int'(resp_credits) - 512 : int'(resp_credits);
    hit = resp_valid && int'(resp_tag) < NT && m_busy[resp_tag];
    e_dv = hit;
    if (hit) begin e_do = m_owner[resp_tag]; e_dt = resp_tag; m_busy[resp_tag] = 0; end
    if (resp_valid && !hit) m_err = 1;
    e_cv = g_ok;
    if (g_ok) begin
      e_cc = req_command[g_win*13 +: 13];
      e_ca = req_address[g_win*64 +: 64];
      e_cs = req_size[g_win*12 +: 12];
      e_ct = g_tag;
      m_busy[g_tag] = 1;
      m_owner[g_tag] = g_win;
      m_rr = (g_win + 1) % NR;
    end
    start_ok = job_start && (old_state == 0 || old_state == 3);
    sum = m_cred - (g_ok ? 1 : 0) + (resp_valid ? rc : 0);
    if (start_ok) begin m_cred = room; m_room = room; end
    else if (sum < 0) begin m_cred = 0; m_err = 1; end
    else if (sum > m_room) begin m_cred = m_room; m_err = 1; end
    else m_cred = sum;
    if (job_start && (old_state == 1 || old_state == 2)) m_err = 1;
    if ((old_state == 0 || old_state == 3) && start_ok) m_state = 1;
    else if (old_state == 1 && drain) m_state = 2;
    else if (old_state == 2 && m_out == 0) m_state = 3;
    m_out = 0;
    for (int t = 0; t < NT; t++) m_out += int'(m_busy[t]);
  endtask

  task automatic cycle();
    for (int i = 0; i < NR; i++) begin
      req_command[i*13 +: 13] = 13'($urandom);
      req_address[i*64 +: 64] = {$urandom, $urandom};
      req_size[i*12 +: 12]    = 12'($urandom);
    end
    last_grant = '0;
    last_tag = 8'hFF;
    #1;
    model_comb();
    check("grant", req_grant, g_ok ? (1 << g_win) : 0);
    if (g_ok) check("grant_tag", grant_tag, g_tag);
    if (|req_grant) begin dut_grants++; last_grant = req_grant; last_tag = grant_tag; end
    @(posedge clk);
    model_clock();
    @(negedge clk);
    check("cmd_valid", cmd_valid, e_cv);
    if (e_cv) begin
      check("cmd_command", cmd_command, e_cc);
      check("cmd_address", cmd_address, e_ca);
      check("cmd_size", cmd_size, e_cs);
      check("cmd_tag", cmd_tag, e_ct);
    end
    check("done_valid", done_valid, e_dv);
    if (e_dv) begin
      check("done_owner", done_owner, e_do);
      check("done_tag", done_tag, e_dt);
    end
    check("outstanding", outstanding, m_out);
    check("drained", drained, m_state == 3);
    check("error", error, m_err);
  endtask

  task automatic quiet();
    job_start = 0; drain = 0; req_valid = '0; resp_valid = 0;
    resp_tag = '0; resp_credits = '0; room = '0;
  endtask

  task automatic restart(input int r);
    quiet(); rst = 1; cycle(); rst = 0;
    job_start = 1; room = 8'(r); cycle(); job_start = 0;
  endtask

  logic [NR-1:0] ord [5];
  logic [NR-1:0] exp_ord [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  int g0;
  int busy_list [$];

  initial begin
    quiet(); rst = 1;
    cycle(); cycle();
    // T1: four credits, one requester asking six times
    restart(4);
    g0 = dut_grants; req_valid = 4'b0001;
    repeat (6) cycle();
    check("t1_grants", dut_grants - g0, 4);
    // T3: response frees tag 2 while tag 0 is granted in the same cycle
    req_valid = '0; resp_valid = 1; resp_tag = 0; resp_credits = 9'd1; cycle();
    req_valid = 4'b0010; resp_tag = 2; resp_credits = 9'd1; cycle();
    check("t3_first_tag", last_tag, 0);
    resp_valid = 0; cycle();
    check("t3_reuse_tag", last_tag, 2);
    req_valid = '0; cycle();
    // T2: all requesters active, pool exhausts at NT tags
    restart(40);
    g0 = dut_grants; req_valid = 4'hF;
    for (int c = 0; c < 34; c++) begin
      cycle();
      if (c < 5) ord[c] = last_grant;
    end
    for (int c = 0; c < 5; c++) check("t2_order", ord[c], exp_ord[c]);
    check("t2_total", dut_grants - g0, NT);
    resp_valid = 1; resp_tag = 5; resp_credits = 9'd1; cycle();
    resp_valid = 0; cycle();
    check("t2_regrant_tag", last_tag, 5);
    req_valid = '0;
    // T4: drain with three tags in flight
    restart(8);
    req_valid = 4'b0001; repeat (3) cycle();
    req_valid = '0; drain = 1; cycle();
    g0 = dut_grants; req_valid = 4'hF; cycle();
    for (int t = 0; t < 3; t++) begin
      resp_valid = 1; resp_tag = 8'(t); resp_credits = 9'd1; cycle();
    end
    resp_valid = 0; repeat (3) cycle();
    check("t4_no_grants", dut_grants - g0, 0);
    check("t4_drained", drained, 1);
    drain = 0; job_start = 1; cycle(); job_start = 0;
    g0 = dut_grants; cycle();
    check("t4_rerun", dut_grants - g0, 1);
    req_valid = '0;
    // T5: response on a free tag, then credit overflow beyond room
    restart(4);
    check("t5_error_clear", error, 0);
    resp_valid = 1; resp_tag = 7; resp_credits = '0; cycle();
    check("t5_free_tag_error", error, 1);
    check("t5_no_done", done_valid, 0);
    resp_valid = 0;
    restart(4);
    req_valid = 4'b0001; cycle(); req_valid = '0;
    resp_valid = 1; resp_tag = 0; resp_credits = 9'd5; cycle();
    check("t5_credit_error", error, 1);
    resp_valid = 0; req_valid = 4'hF; g0 = dut_grants;
    repeat (6) cycle();
    check("t5_clamped", dut_grants - g0, 4);
    // T6: reset one cycle after a grant
    restart(4);
    req_valid = 4'b0001; cycle();
    req_valid = '0; rst = 1; cycle(); rst = 0;
    check("t6_cmd_valid", cmd_valid, 0);
    check("t6_outstanding", outstanding, 0);
    g0 = dut_grants; req_valid = 4'hF; cycle();
    check("t6_idle_no_grant", dut_grants - g0, 0);
    // random traffic
    restart(20);
    for (int c = 0; c < 4000; c++) begin
      quiet();
      drain = (c % 500) > 430;
      req_valid = NR'($urandom);
      if ((m_state == 0 || m_state == 3) ? ($urandom % 5 == 0) : ($urandom % 300 == 0)) begin
        job_start = 1; room = 8'($urandom_range(1, 40));
      end
      if ($urandom % 2 == 0) begin
        busy_list.delete();
        for (int t = 0; t < NT; t++) if (m_busy[t]) busy_list.push_back(t);
        resp_valid = 1;
        resp_tag = (busy_list.size() > 0 && $urandom % 10 != 0)
                   ? 8'(busy_list[$urandom % busy_list.size()]) : 8'($urandom_range(0, 40));
        case ($urandom % 16)
          0: resp_credits = 9'h1FF;
          1: resp_credits = 9'd0;
          2: resp_credits = 9'd2;
          default: resp_credits = 9'd1;
        endcase
      end
      rst = ($urandom % 700 == 0);
      cycle();
    end
    rst = 0; quiet(); cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
